// File: rtl/pcie_consts.sv
// Shared types and constants for the PCIe Bursting Avalon Slave write path.
// Used by the BAS write arbiter and its round-robin picker.
package pcie_consts;

  localparam int BAS_BURST_W   = 4;
  localparam int MAX_BURST_DEF = 8;

  // One requester's write beat, in the same order as the flattened port slices.
  typedef struct packed {
    logic [63:0]            address;
    logic [63:0]            byteenable;
    logic [511:0]           writedata;
    logic [BAS_BURST_W-1:0] burstcount;
  } bas_wr_req_t;

  // FIRST = grant locked but the first beat (and its burstcount) not yet accepted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  function automatic logic burst_legal(input logic [BAS_BURST_W-1:0] bc,
                                       input int max_burst);
    return (bc != '0) && (int'(bc) <= max_burst);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest asserted request at or above ptr,
// wrapping modulo NUM_REQ. Provides both index and one-hot forms.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      sel,
  output logic [NUM_REQ-1:0] sel_onehot,
  output logic               valid
);

  always_comb begin
    logic [PW:0] idx;
    sel        = '0;
    valid      = 1'b0;
    sel_onehot = '0;
    idx        = '0;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) begin
        idx = idx - (PW+1)'(NUM_REQ);
      end
      if (req[idx[PW-1:0]]) begin
        sel   = idx[PW-1:0];
        valid = 1'b1;
      end
    end
    if (valid) begin
      sel_onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/pcie_bas_wr_arbiter.sv
// Burst-atomic round-robin arbiter sharing one PCIe BAS write port among
// NUM_REQ DMA write masters, with zero-cycle pass-through and statistics.
module pcie_bas_wr_arbiter
  import pcie_consts::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_reset,
  input  logic [NUM_REQ*64-1:0]         rq_address,
  input  logic [NUM_REQ*64-1:0]         rq_byteenable,
  input  logic [NUM_REQ*512-1:0]        rq_writedata,
  input  logic [NUM_REQ*4-1:0]          rq_burstcount,
  input  logic [NUM_REQ-1:0]            rq_write,
  output logic [NUM_REQ-1:0]            rq_waitrequest,
  input  logic                          pcie_bas_waitrequest,
  output logic [63:0]                   pcie_bas_address,
  output logic [63:0]                   pcie_bas_byteenable,
  output logic                          pcie_bas_write,
  output logic [511:0]                  pcie_bas_writedata,
  output logic [3:0]                    pcie_bas_burstcount,
  output logic                          pcie_bas_read,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  burst_cnt,
  output logic [CNT_WIDTH-1:0]          proto_err_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  bas_wr_req_t req_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_arr[gi] = {rq_address[64*gi +: 64],
                          rq_byteenable[64*gi +: 64],
                          rq_writedata[512*gi +: 512],
                          rq_burstcount[BAS_BURST_W*gi +: BAS_BURST_W]};
  end

  arb_state_t             state_q, state_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [BAS_BURST_W-1:0] beats_left_q, beats_left_d;

  logic [PW-1:0]          sel;
  logic [NUM_REQ-1:0]     sel_onehot;
  logic                   pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req        (rq_write),
    .ptr        (rr_ptr_q),
    .sel        (sel),
    .sel_onehot (sel_onehot),
    .valid      (pick_valid)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0]          cur_idx;
  logic                   active;
  logic                   first_beat;
  bas_wr_req_t            cur_req;
  logic                   bc_ok;
  logic [BAS_BURST_W-1:0] eff_bc;
  logic                   accept;
  logic [NUM_REQ-1:0]     grant_onehot;

  // Once a burst is presented the mux follows grant_q, so a stalled beat never moves.
  always_comb begin
    cur_idx    = sel;
    active     = pick_valid;
    first_beat = 1'b1;
    case (state_q)
      ST_FIRST: begin
        cur_idx = grant_q;
        active  = 1'b1;
      end
      ST_LOCKED: begin
        cur_idx    = grant_q;
        active     = 1'b1;
        first_beat = 1'b0;
      end
      default: ;
    endcase
  end

  assign cur_req      = req_arr[cur_idx];
  assign bc_ok        = burst_legal(cur_req.burstcount, MAX_BURST);
  assign eff_bc       = (first_beat && !bc_ok) ? BAS_BURST_W'(1) : cur_req.burstcount;
  assign grant_onehot = NUM_REQ'(1) << grant_q;

  assign pcie_bas_write      = !rst && active && rq_write[cur_idx];
  assign pcie_bas_address    = cur_req.address;
  assign pcie_bas_byteenable = cur_req.byteenable;
  assign pcie_bas_writedata  = cur_req.writedata;
  assign pcie_bas_burstcount = eff_bc;
  assign pcie_bas_read       = 1'b0;
  assign accept              = pcie_bas_write && !pcie_bas_waitrequest;

  always_comb begin
    rq_waitrequest = '1;
    if (!rst && active) begin
      rq_waitrequest[cur_idx] = pcie_bas_waitrequest;
    end
  end

  logic [NUM_REQ-1:0] burst_done;
  logic               proto_hit;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    burst_done   = '0;
    proto_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = sel;
          if (accept) begin
            proto_hit = !bc_ok;
            if (eff_bc == BAS_BURST_W'(1)) begin
              rr_ptr_d   = ptr_inc(sel);
              burst_done = sel_onehot;
            end else begin
              state_d      = ST_LOCKED;
              beats_left_d = eff_bc - 1'b1;
            end
          end else begin
            state_d      = ST_FIRST;
            beats_left_d = eff_bc;
          end
        end
      end
      ST_FIRST: begin
        if (accept) begin
          proto_hit = !bc_ok;
          if (beats_left_q == BAS_BURST_W'(1)) begin
            state_d      = ST_IDLE;
            rr_ptr_d     = ptr_inc(grant_q);
            burst_done   = grant_onehot;
            beats_left_d = '0;
          end else begin
            state_d      = ST_LOCKED;
            beats_left_d = beats_left_q - 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == BAS_BURST_W'(1)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = ptr_inc(grant_q);
            burst_done = grant_onehot;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Statistics: saturating, and a clear wins over a same-cycle increment.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (sw_reset) begin
        cnt_d = '0;
      end else if (burst_done[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign burst_cnt[CNT_WIDTH*gi +: CNT_WIDTH] = cnt_q;
  end

  logic [CNT_WIDTH-1:0] proto_err_cnt_q, proto_err_cnt_d;

  always_comb begin
    proto_err_cnt_d = proto_err_cnt_q;
    if (sw_reset) begin
      proto_err_cnt_d = '0;
    end else if (proto_hit && (proto_err_cnt_q != '1)) begin
      proto_err_cnt_d = proto_err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) proto_err_cnt_q <= '0;
    else     proto_err_cnt_q <= proto_err_cnt_d;
  end

  assign proto_err_cnt = proto_err_cnt_q;

endmodule

// File: tb/tb_pcie_bas_wr_arbiter.sv
// Scoreboard bench for pcie_bas_wr_arbiter: per-requester burst drivers, a BAS
// beat monitor, and one task per scenario.
module tb_pcie_bas_wr_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_reset;
  logic [127:0]  rq_address;
  logic [127:0]  rq_byteenable;
  logic [1023:0] rq_writedata;
  logic [7:0]    rq_burstcount;
  logic [1:0]    rq_write;
  logic [1:0]    rq_waitrequest;
  logic          pcie_bas_waitrequest;
  logic [63:0]   pcie_bas_address;
  logic [63:0]   pcie_bas_byteenable;
  logic          pcie_bas_write;
  logic [511:0]  pcie_bas_writedata;
  logic [3:0]    pcie_bas_burstcount;
  logic          pcie_bas_read;
  logic [63:0]   burst_cnt;
  logic [31:0]   proto_err_cnt;

  pcie_bas_wr_arbiter #(.NUM_REQ(2), .MAX_BURST(8), .CNT_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sw_reset             (sw_reset),
    .rq_address           (rq_address),
    .rq_byteenable        (rq_byteenable),
    .rq_writedata         (rq_writedata),
    .rq_burstcount        (rq_burstcount),
    .rq_write             (rq_write),
    .rq_waitrequest       (rq_waitrequest),
    .pcie_bas_waitrequest (pcie_bas_waitrequest),
    .pcie_bas_address     (pcie_bas_address),
    .pcie_bas_byteenable  (pcie_bas_byteenable),
    .pcie_bas_write       (pcie_bas_write),
    .pcie_bas_writedata   (pcie_bas_writedata),
    .pcie_bas_burstcount  (pcie_bas_burstcount),
    .pcie_bas_read        (pcie_bas_read),
    .burst_cnt            (burst_cnt),
    .proto_err_cnt        (proto_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic [63:0]  be;
    logic [511:0] data;
    logic [3:0]   bc;
    bit           first;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_burst [2];
  int   exp_proto = 0;
  int   first_acc_cyc [2];
  int   last_acc_cyc [2];

  logic        d_act [2];
  logic [63:0] d_addr [2];
  logic [3:0]  d_bc [2];
  int          d_len [2];
  int          d_beat [2];
  int          d_auto [2];

  function automatic logic [511:0] data_of(input int r, input logic [63:0] a);
    logic [63:0] w;
    w = a ^ (64'(r + 1) << 56);
    return {8{w}};
  endfunction

  function automatic logic [63:0] be_of(input logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      logic [63:0] a;
      a = d_addr[r] + 64'(d_beat[r]) * 64'd64;
      rq_write[r]                 = d_act[r];
      rq_address[64*r +: 64]      = a;
      rq_byteenable[64*r +: 64]   = be_of(a);
      rq_writedata[512*r +: 512]  = data_of(r, a);
      rq_burstcount[4*r +: 4]     = (d_beat[r] == 0) ? d_bc[r] : 4'd0;
    end
  endtask

  task automatic start(input int r, input logic [63:0] a, input int len,
                       input logic [3:0] bc, input int rep);
    d_act[r]  = 1'b1;
    d_addr[r] = a;
    d_len[r]  = len;
    d_bc[r]   = bc;
    d_beat[r] = 0;
    d_auto[r] = rep;
  endtask

  // Expected beats of one burst, in the order the BAS must carry them.
  task automatic push_burst(input int r, input logic [63:0] a, input int len,
                            input logic [3:0] bc);
    exp_t e;
    for (int b = 0; b < len; b++) begin
      e.addr  = a + 64'(b) * 64'd64;
      e.be    = be_of(e.addr);
      e.data  = data_of(r, e.addr);
      e.first = (b == 0);
      e.bc    = (bc == 4'd0 || bc > 4'd8) ? 4'd1 : bc;
      sb.push_back(e);
    end
    exp_burst[r]++;
    if (bc == 4'd0 || bc > 4'd8) exp_proto++;
  endtask

  // One clock: monitor at negedge, advance drivers just after posedge.
  task automatic cycle();
    logic [1:0] acc;
    exp_t e;
    @(negedge clk);
    acc = rq_write & ~rq_waitrequest;
    if (pcie_bas_write && !pcie_bas_waitrequest) begin
      $display("beat cyc=%0d addr=%h bc=%0d", cyc, pcie_bas_address, pcie_bas_burstcount);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: addr=%h, required no beat", pcie_bas_address);
      end else begin
        e = sb.pop_front();
        if (pcie_bas_address !== e.addr) begin
          errors++;
          $display("FAIL beat_addr: got %h required %h", pcie_bas_address, e.addr);
        end
        checks++;
        if (pcie_bas_writedata !== e.data) begin
          errors++;
          $display("FAIL beat_data: got %h required %h", pcie_bas_writedata, e.data);
        end
        checks++;
        if (pcie_bas_byteenable !== e.be) begin
          errors++;
          $display("FAIL beat_be: got %h required %h", pcie_bas_byteenable, e.be);
        end
        if (e.first) begin
          checks++;
          if (pcie_bas_burstcount !== e.bc) begin
            errors++;
            $display("FAIL beat_bc: got %0d required %0d", pcie_bas_burstcount, e.bc);
          end
        end
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (acc[r] && d_act[r]) begin
        if (d_beat[r] == 0) first_acc_cyc[r] = cyc;
        last_acc_cyc[r] = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int r = 0; r < 2; r++) begin
      if (acc[r] && d_act[r]) begin
        d_beat[r]++;
        if (d_beat[r] == d_len[r]) begin
          d_beat[r] = 0;
          if (d_auto[r] > 1) begin
            d_auto[r]--;
            d_addr[r] = d_addr[r] + 64'(d_len[r]) * 64'd64;
          end else begin
            d_act[r] = 1'b0;
          end
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || d_act[0] || d_act[1]) && n < 300) begin
      cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0 || d_act[0] || d_act[1]) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
      sb.delete();
      d_act[0] = 1'b0;
      d_act[1] = 1'b0;
      drive();
      #1;
    end
  endtask

  task automatic test_reset();
    start(0, 64'h500, 1, 4'd1, 1);
    drive();
    @(negedge clk);
    checks++;
    if (pcie_bas_write !== 1'b0) begin
      errors++; $display("FAIL rst_write: got %b required 0", pcie_bas_write);
    end
    checks++;
    if (rq_waitrequest !== 2'b11) begin
      errors++; $display("FAIL rst_waitreq: got %b required 11", rq_waitrequest);
    end
    checks++;
    if (pcie_bas_read !== 1'b0) begin
      errors++; $display("FAIL rst_read: got %b required 0", pcie_bas_read);
    end
    checks++;
    if (burst_cnt !== 64'd0 || proto_err_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_counters: got %h/%h required 0", burst_cnt, proto_err_cnt);
    end
    d_act[0] = 1'b0;
    @(posedge clk);
    #1;
    drive();
    rst = 1'b0;
    #1;
    checks++;
    if (rq_waitrequest !== 2'b11 || pcie_bas_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_noreq: waitreq=%b write=%b required 11/0", rq_waitrequest, pcie_bas_write);
    end
  endtask

  task automatic test_single_beat();
    start(0, 64'h1000, 1, 4'd1, 1);
    push_burst(0, 64'h1000, 1, 4'd1);
    drive();
    #1;
    checks++;
    if (pcie_bas_write !== 1'b1 || pcie_bas_address !== 64'h1000) begin
      errors++;
      $display("FAIL single_passthru: write=%b addr=%h required 1/1000", pcie_bas_write, pcie_bas_address);
    end
    checks++;
    if (rq_waitrequest !== 2'b10) begin
      errors++; $display("FAIL single_waitreq: got %b required 10", rq_waitrequest);
    end
    drain("single");
    checks++;
    if (burst_cnt[31:0] !== 32'(exp_burst[0])) begin
      errors++; $display("FAIL single_cnt: got %0d required %0d", burst_cnt[31:0], exp_burst[0]);
    end
  endtask

  task automatic test_burst_atomicity();
    bit started1;
    started1 = 1'b0;
    start(0, 64'h2000, 8, 4'd8, 1);
    push_burst(0, 64'h2000, 8, 4'd8);
    drive();
    #1;
    for (int n = 0; n < 40 && (d_act[0] || d_act[1]); n++) begin
      cycle();
      if (!started1 && d_act[0] && d_beat[0] == 2) begin
        start(1, 64'h9000, 1, 4'd1, 1);
        push_burst(1, 64'h9000, 1, 4'd1);
        drive();
        #1;
        started1 = 1'b1;
      end
      if (started1 && d_act[0] && d_act[1]) begin
        checks++;
        if (rq_waitrequest[1] !== 1'b1) begin
          errors++; $display("FAIL atomic_waitreq1: got %b required 1 at rq0 beat %0d", rq_waitrequest[1], d_beat[0]);
        end
      end
    end
    drain("atomic");
    checks++;
    if (first_acc_cyc[1] != last_acc_cyc[0] + 1) begin
      errors++;
      $display("FAIL atomic_nobubble: rq1 at cyc %0d required %0d", first_acc_cyc[1], last_acc_cyc[0] + 1);
    end
  endtask

  task automatic test_round_robin();
    start(0, 64'h10000, 1, 4'd1, 10);
    start(1, 64'h20000, 1, 4'd1, 10);
    for (int i = 0; i < 10; i++) begin
      push_burst(0, 64'h10000 + 64'(i) * 64'd64, 1, 4'd1);
      push_burst(1, 64'h20000 + 64'(i) * 64'd64, 1, 4'd1);
    end
    drive();
    #1;
    drain("rr");
    checks++;
    if (burst_cnt[31:0] !== 32'(exp_burst[0]) || burst_cnt[63:32] !== 32'(exp_burst[1])) begin
      errors++;
      $display("FAIL rr_cnt: got %0d/%0d required %0d/%0d", burst_cnt[31:0], burst_cnt[63:32], exp_burst[0], exp_burst[1]);
    end
  endtask

  task automatic test_first_beat_stall();
    // A lone rq0 beat first moves the pointer to rq1, so a moving grant would show.
    start(0, 64'h2F00, 1, 4'd1, 1);
    push_burst(0, 64'h2F00, 1, 4'd1);
    drive();
    #1;
    drain("stall_pre");
    pcie_bas_waitrequest = 1'b1;
    start(0, 64'h3000, 4, 4'd4, 1);
    push_burst(0, 64'h3000, 4, 4'd4);
    drive();
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (pcie_bas_write !== 1'b1 || pcie_bas_address !== 64'h3000 || pcie_bas_burstcount !== 4'd4) begin
        errors++;
        $display("FAIL stall_hold: s=%0d write=%b addr=%h bc=%0d required 1/3000/4", s, pcie_bas_write, pcie_bas_address, pcie_bas_burstcount);
      end
      checks++;
      if (rq_waitrequest !== 2'b11) begin
        errors++; $display("FAIL stall_waitreq: s=%0d got %b required 11", s, rq_waitrequest);
      end
      cycle();
      if (s == 0) begin
        start(1, 64'hA000, 1, 4'd1, 1);
        push_burst(1, 64'hA000, 1, 4'd1);
        drive();
        #1;
      end
    end
    pcie_bas_waitrequest = 1'b0;
    #1;
    drain("stall");
  endtask

  task automatic test_protocol_error();
    start(1, 64'hB000, 1, 4'd0, 1);
    push_burst(1, 64'hB000, 1, 4'd0);
    drive();
    #1;
    checks++;
    if (pcie_bas_burstcount !== 4'd1) begin
      errors++; $display("FAIL proto_bc0: got %0d required 1", pcie_bas_burstcount);
    end
    cycle();
    start(0, 64'hB100, 1, 4'd1, 1);
    push_burst(0, 64'hB100, 1, 4'd1);
    drive();
    #1;
    checks++;
    if (rq_waitrequest[0] !== 1'b0 || pcie_bas_write !== 1'b1) begin
      errors++;
      $display("FAIL proto_idle: waitreq0=%b write=%b required 0/1", rq_waitrequest[0], pcie_bas_write);
    end
    cycle();
    start(1, 64'hB200, 1, 4'd9, 1);
    push_burst(1, 64'hB200, 1, 4'd9);
    drive();
    #1;
    drain("proto");
    checks++;
    if (proto_err_cnt !== 32'(exp_proto)) begin
      errors++; $display("FAIL proto_cnt: got %0d required %0d", proto_err_cnt, exp_proto);
    end
    // A burst completing in the sw_reset cycle must not survive the clear.
    sw_reset = 1'b1;
    start(0, 64'hB300, 1, 4'd1, 1);
    push_burst(0, 64'hB300, 1, 4'd1);
    drive();
    #1;
    cycle();
    sw_reset = 1'b0;
    exp_burst[0] = 0;
    exp_burst[1] = 0;
    exp_proto    = 0;
    #1;
    checks++;
    if (burst_cnt !== 64'd0 || proto_err_cnt !== 32'd0) begin
      errors++; $display("FAIL swreset_clear: got %h/%h required 0", burst_cnt, proto_err_cnt);
    end
    start(0, 64'hB400, 1, 4'd1, 1);
    push_burst(0, 64'hB400, 1, 4'd1);
    drive();
    #1;
    drain("swreset");
    checks++;
    if (burst_cnt[31:0] !== 32'(exp_burst[0])) begin
      errors++; $display("FAIL swreset_after: got %0d required %0d", burst_cnt[31:0], exp_burst[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    start(0, 64'hC000, 1, 4'd1, 1);
    push_burst(0, 64'hC000, 1, 4'd1);
    drive();
    #1;
    drain("rstmid_pre");
    start(0, 64'hD000, 8, 4'd8, 1);
    push_burst(0, 64'hD000, 8, 4'd8);
    repeat (6) void'(sb.pop_back());
    drive();
    #1;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (pcie_bas_write !== 1'b0 || rq_waitrequest !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_gate: write=%b waitreq=%b required 0/11", pcie_bas_write, rq_waitrequest);
    end
    cycle();
    d_act[0] = 1'b0;
    d_beat[0] = 0;
    drive();
    rst = 1'b0;
    exp_burst[0] = 0;
    exp_burst[1] = 0;
    exp_proto    = 0;
    #1;
    checks++;
    if (pcie_bas_write !== 1'b0 || burst_cnt !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_after: write=%b cnt=%h required 0/0", pcie_bas_write, burst_cnt);
    end
    start(1, 64'hE000, 1, 4'd1, 1);
    start(0, 64'hD800, 8, 4'd8, 1);
    push_burst(0, 64'hD800, 8, 4'd8);
    push_burst(1, 64'hE000, 1, 4'd1);
    drive();
    #1;
    drain("rstmid");
    checks++;
    if (burst_cnt[31:0] !== 32'(exp_burst[0]) || burst_cnt[63:32] !== 32'(exp_burst[1])) begin
      errors++;
      $display("FAIL rstmid_cnt: got %0d/%0d required %0d/%0d", burst_cnt[31:0], burst_cnt[63:32], exp_burst[0], exp_burst[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    sw_reset = 1'b0;
    pcie_bas_waitrequest = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d_act[r] = 1'b0; d_addr[r] = '0; d_bc[r] = '0;
      d_len[r] = 1; d_beat[r] = 0; d_auto[r] = 0;
      exp_burst[r] = 0; first_acc_cyc[r] = -10; last_acc_cyc[r] = -10;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_burst_atomicity();
    test_round_robin();
    test_first_beat_stall();
    test_protocol_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
